// File: rtl/conv5x5_filt.sv
// conv5x5_filt: 5x5 signed-kernel convolution on a streaming pixel channel.
//
// Takes five vertically aligned row taps (pa = newest line .. pe = oldest line)
// every clock, builds a 5x5 window with horizontal shift registers and convolves
// it with a runtime-loadable double-buffered signed kernel. The result is
// rounded (half up), right-shifted by SHIFT and clipped to 8 bits.
// Taps presented in cycle t, as the window centre, come out on pix_o in cycle t+7.
//
// Ports:
//   clk, rst             pixel clock, synchronous active-high reset
//   pa..pe               row taps, row 0 (newest line) .. row 4 (oldest line)
//   stat_in              status bit travelling with the taps
//   coef_we/addr/data    write one shadow kernel entry, index r*5+c (25..31 ignored)
//   coef_load            copy the whole shadow kernel into the active kernel
//   pix_o                filtered pixel
//   stat_o               stat_in delayed to line up with pix_o
//   sat_o                pix_o was clipped at 0 or 255
module conv5x5_filt #(
  parameter int unsigned SHIFT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pa,
  input  logic [7:0] pb,
  input  logic [7:0] pc,
  input  logic [7:0] pd,
  input  logic [7:0] pe,
  input  logic       stat_in,
  input  logic       coef_we,
  input  logic [4:0] coef_addr,
  input  logic [7:0] coef_data,
  input  logic       coef_load,
  output logic [7:0] pix_o,
  output logic       stat_o,
  output logic       sat_o
);

  localparam int unsigned NTap = 25;
  localparam int unsigned CentreIdx = 12;
  // Identity gain 2^SHIFT does not fit a signed byte at SHIFT=7, so clamp it.
  localparam logic [7:0] IdCoef = (SHIFT >= 7) ? 8'd127 : 8'(32'd1 << SHIFT);
  localparam logic signed [22:0] Rnd = 23'((32'd1 << SHIFT) >> 1);

  logic [7:0]         tap [5];
  logic [7:0]         win_q [5][5];
  logic signed [7:0]  kshd_q [NTap];
  logic signed [7:0]  kact_q [NTap];
  logic signed [16:0] prod_d [NTap];
  logic signed [16:0] prod_q [NTap];
  logic signed [19:0] rsum_d [5];
  logic signed [19:0] rsum_q [5];
  logic signed [21:0] tot_d, tot_q;
  logic signed [22:0] rnd_sum, norm;
  logic [7:0]         pix_d, pix_q;
  logic               sat_d, sat_q;
  logic [6:0]         stat_q;

  assign tap[0] = pa;
  assign tap[1] = pb;
  assign tap[2] = pc;
  assign tap[3] = pd;
  assign tap[4] = pe;

  // Window: column 0 takes the new taps, older columns shift right.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < 5; r++) begin
        win_q[r][0] <= tap[r];
        for (int c = 1; c < 5; c++) begin
          win_q[r][c] <= win_q[r][c-1];
        end
      end
    end
  end

  // Kernel: the load copies the shadow as it stood before any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTap; i++) begin
        kshd_q[i] <= (i == CentreIdx) ? IdCoef : '0;
        kact_q[i] <= (i == CentreIdx) ? IdCoef : '0;
      end
    end else begin
      if (coef_load) begin
        for (int i = 0; i < NTap; i++) begin
          kact_q[i] <= kshd_q[i];
        end
      end
      if (coef_we && (coef_addr < 5'd25)) begin
        kshd_q[coef_addr] <= coef_data;
      end
    end
  end

  // Stage 1: unsigned pixel times signed coefficient, both widened to 17 bits.
  always_comb begin
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        prod_d[r*5+c] = signed'({9'd0, win_q[r][c]}) *
                        signed'({{9{kact_q[r*5+c][7]}}, kact_q[r*5+c]});
      end
    end
  end

  // Stage 2: row sums.
  always_comb begin
    for (int r = 0; r < 5; r++) begin
      rsum_d[r] = '0;
      for (int c = 0; c < 5; c++) begin
        rsum_d[r] = rsum_d[r] + 20'(prod_q[r*5+c]);
      end
    end
  end

  // Stage 3: total; 22 bits cannot overflow for 25 taps of 255 x 128.
  always_comb begin
    tot_d = '0;
    for (int r = 0; r < 5; r++) begin
      tot_d = tot_d + 22'(rsum_q[r]);
    end
  end

  // Stage 4: round half up, arithmetic shift, clip to 0..255.
  always_comb begin
    rnd_sum = 23'(tot_q) + Rnd;
    norm    = rnd_sum >>> SHIFT;
    pix_d   = norm[7:0];
    sat_d   = 1'b0;
    if (norm[22]) begin
      pix_d = 8'd0;
      sat_d = 1'b1;
    end else if (|norm[21:8]) begin
      pix_d = 8'd255;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTap; i++) begin
        prod_q[i] <= '0;
      end
      for (int r = 0; r < 5; r++) begin
        rsum_q[r] <= '0;
      end
      tot_q  <= '0;
      pix_q  <= '0;
      sat_q  <= 1'b0;
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NTap; i++) begin
        prod_q[i] <= prod_d[i];
      end
      for (int r = 0; r < 5; r++) begin
        rsum_q[r] <= rsum_d[r];
      end
      tot_q  <= tot_d;
      pix_q  <= pix_d;
      sat_q  <= sat_d;
      stat_q <= {stat_q[5:0], stat_in};
    end
  end

  assign pix_o  = pix_q;
  assign sat_o  = sat_q;
  assign stat_o = stat_q[6];

endmodule

// File: tb/tb_conv5x5_filt.sv
// Self-checking bench for conv5x5_filt. A cycle-indexed history of inputs and
// of the modelled active kernel gives the expected output of every cycle as a
// direct 5x5 weighted sum of past taps, with resets discarding older samples.
module tb_conv5x5_filt;

  localparam int Shift = 4;
  localparam int NCyc  = 4000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pa, pb, pc, pd, pe;
  logic       stat_in, coef_we, coef_load;
  logic [4:0] coef_addr;
  logic [7:0] coef_data;
  logic [7:0] pix_o;
  logic       stat_o, sat_o;

  conv5x5_filt #(.SHIFT(Shift)) dut (
    .clk       (clk),
    .rst       (rst),
    .pa        (pa),
    .pb        (pb),
    .pc        (pc),
    .pd        (pd),
    .pe        (pe),
    .stat_in   (stat_in),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_load (coef_load),
    .pix_o     (pix_o),
    .stat_o    (stat_o),
    .sat_o     (sat_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int tap_h [NCyc][5];
  bit rst_h [NCyc];
  bit stat_h [NCyc];
  int k_h [NCyc][25];
  int shd [25];
  int act [25];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int id_coef();
    return (Shift >= 7) ? 127 : (1 << Shift);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 25; i++) begin
      shd[i] = (i == 12) ? id_coef() : 0;
      act[i] = shd[i];
    end
  endfunction

  function automatic bit rst_between(input int a, input int b);
    for (int j = a; j <= b; j++) begin
      if (j >= 0 && rst_h[j]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Unclipped normalised result for the output visible in cycle n: the window
  // centred on the taps of cycle n-7, weighted by the kernel active in cycle n-4.
  function automatic int exp_norm(input int n);
    int acc = 0;
    if (n < 4) return 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        int j = n - 5 - c;
        if (j >= 0 && !rst_between(j, n - 1))
          acc += tap_h[j][r] * k_h[n-4][r*5+c];
      end
    end
    acc += (Shift > 0) ? (1 << (Shift - 1)) : 0;
    return acc >>> Shift;
  endfunction

  task automatic step();
    int u, ep, es, est;
    tap_h[cyc][0] = pa;
    tap_h[cyc][1] = pb;
    tap_h[cyc][2] = pc;
    tap_h[cyc][3] = pd;
    tap_h[cyc][4] = pe;
    rst_h[cyc]  = rst;
    stat_h[cyc] = stat_in;
    for (int i = 0; i < 25; i++) k_h[cyc][i] = act[i];
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (coef_load) act = shd;
      if (coef_we && coef_addr < 25) begin
        int v = coef_data;
        shd[coef_addr] = (v > 127) ? v - 256 : v;
      end
    end
    cyc++;
    #1;
    u   = exp_norm(cyc);
    ep  = (u < 0) ? 0 : (u > 255) ? 255 : u;
    es  = (u < 0 || u > 255) ? 1 : 0;
    est = (cyc >= 7 && stat_h[cyc-7] && !rst_between(cyc - 7, cyc - 1)) ? 1 : 0;
    check_eq("pix", pix_o, ep);
    check_eq("sat", sat_o, es);
    check_eq("stat", stat_o, est);
  endtask

  task automatic rand_taps();
    pa = 8'($urandom);
    pb = 8'($urandom);
    pc = 8'($urandom);
    pd = 8'($urandom);
    pe = 8'($urandom);
  endtask

  task automatic const_taps(input logic [7:0] v);
    pa = v; pb = v; pc = v; pd = v; pe = v;
  endtask

  task automatic write_coef(input int addr, input logic [7:0] data);
    coef_we = 1'b1; coef_addr = 5'(addr); coef_data = data;
    step();
    coef_we = 1'b0;
  endtask

  task automatic load_kernel();
    coef_load = 1'b1;
    step();
    coef_load = 1'b0;
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; stat_in = 1'b0; coef_we = 1'b0; coef_load = 1'b0;
    coef_addr = '0; coef_data = '0;
    const_taps(8'd0);
    model_reset();
    run_steps(2);
    check_eq("reset_pix", pix_o, 0);
    rst = 1'b0;

    // Identity kernel: centre tap ramp reappears 7 cycles later.
    for (int i = 0; i < 100; i++) begin
      rand_taps();
      pc = 8'(i);
      stat_in = (i >= 10 && i <= 19);
      step();
    end
    stat_in = 1'b0;
    run_steps(8);

    // Box filter of all ones.
    for (int i = 0; i < 25; i++) begin
      rand_taps();
      write_coef(i, 8'd1);
    end
    load_kernel();
    const_taps(8'd160);
    run_steps(12);
    check_eq("box160_pix", pix_o, 250);
    check_eq("box160_sat", sat_o, 0);
    const_taps(8'd200);
    run_steps(12);
    check_eq("box200_pix", pix_o, 255);
    check_eq("box200_sat", sat_o, 1);

    // Negative centre coefficient clips to zero.
    for (int i = 0; i < 25; i++) write_coef(i, (i == 12) ? 8'hF0 : 8'h00);
    load_kernel();
    const_taps(8'd50);
    run_steps(12);
    check_eq("neg_pix", pix_o, 0);
    check_eq("neg_sat", sat_o, 1);
    for (int i = 0; i < 25; i++) begin
      write_coef(i, (i == 12) ? 8'hFF : (i == 0) ? 8'd16 : 8'h00);
    end
    load_kernel();
    rand_taps();
    pa = 8'd100; pc = 8'd0;
    run_steps(12);
    check_eq("mix_pix", pix_o, 100);

    // Shadow writes without a load leave the output alone.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rand_taps();
      write_coef($urandom_range(0, 24), 8'($urandom));
    end
    rst = 1'b1; step(); rst = 1'b0;
    const_taps(8'd60);
    run_steps(8);
    // Write and load together: active kernel gets the pre-write shadow.
    coef_load = 1'b1;
    write_coef(12, 8'd32);
    coef_load = 1'b0;
    run_steps(8);
    check_eq("wl_same_pix", pix_o, 60);
    load_kernel();
    run_steps(3);
    check_eq("load_m1_pix", pix_o, 60);
    step();
    check_eq("load_pix", pix_o, 120);

    // Reset mid-stream discards in-flight data and restores identity.
    const_taps(8'd0);
    run_steps(6);
    const_taps(8'd200);
    stat_in = 1'b1;
    run_steps(3);
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("midrst_pix", pix_o, 0);
    check_eq("midrst_stat", stat_o, 0);
    check_eq("midrst_sat", sat_o, 0);
    for (int i = 0; i < 14; i++) begin
      rand_taps();
      step();
    end
    stat_in = 1'b0;

    // Out-of-range addresses are ignored.
    for (int a = 25; a < 32; a++) write_coef(a, 8'h7F);
    load_kernel();
    for (int i = 0; i < 30; i++) begin
      rand_taps();
      stat_in = 1'($urandom);
      step();
    end

    // Random traffic: kernel updates, loads, status and occasional resets.
    for (int i = 0; i < 600; i++) begin
      rand_taps();
      stat_in   = 1'($urandom);
      rst       = ($urandom_range(0, 99) == 0);
      coef_we   = ($urandom_range(0, 3) == 0);
      coef_addr = 5'($urandom);
      coef_data = 8'($urandom_range(0, 40)) - 8'd12;
      coef_load = ($urandom_range(0, 19) == 0);
      step();
    end
    rst = 1'b0; coef_we = 1'b0; coef_load = 1'b0;
    run_steps(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
